// File: rtl/trace_fifo_pkg.sv
// Shared types and helpers for the trace buffer FIFO.
package trace_fifo_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Sticky flag update: a new event in the same cycle beats a clear.
  function automatic logic sticky(input logic q, input logic clr, input logic evt);
    return (q & ~clr) | evt;
  endfunction

endpackage

// File: rtl/trace_fifo_ram.sv
// Storage for trace_fifo: one write port, asynchronous read port, no reset.
module trace_fifo_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_fifo.sv
// Single-clock trace FIFO: arbitrary depth, FWFT or registered read,
// programmable thresholds, flush, sticky error flags and peak occupancy.
module trace_fifo
  import trace_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_DEPTH = 8,
  parameter  int SHOW_AHEAD = 1,
  parameter  int AF_LEVEL   = DATA_DEPTH - 2,
  parameter  int AE_LEVEL   = 1,
  localparam int CW         = $clog2(DATA_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  flush,
  input  logic                  clr_flags,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         peak,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DATA_DEPTH);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_nxt, peak_q;
  err_flags_t            err_q, err_evt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_q;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DATA_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_q == CW'(DATA_DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign peak         = peak_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

  // Flush masks both requests, so it never sets a flag or fires a read.
  assign wr_acc            = wr_en & ~full  & ~flush;
  assign rd_acc            = rd_en & ~empty & ~flush;
  assign err_evt.overflow  = wr_en & full  & ~flush;
  assign err_evt.underflow = rd_en & empty & ~flush;

  always_comb begin
    count_nxt = count_q;
    if (flush)                count_nxt = '0;
    else if (wr_acc & ~rd_acc) count_nxt = count_q + 1'b1;
    else if (rd_acc & ~wr_acc) count_nxt = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      peak_q  <= '0;
      err_q   <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
        if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      end
      count_q <= count_nxt;
      if (clr_flags || (count_nxt > peak_q)) peak_q <= count_nxt;
      err_q.overflow  <= sticky(err_q.overflow,  clr_flags, err_evt.overflow);
      err_q.underflow <= sticky(err_q.underflow, clr_flags, err_evt.underflow);
    end
  end

  trace_fifo_ram #(
    .DW   (DATA_WIDTH),
    .DEPTH(DATA_DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(ram_q)
  );

  if (SHOW_AHEAD != 0) begin : g_fwft
    assign rd_data  = ram_q;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_q;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: doc/trace_fifo.md
# trace_fifo

Parametrised single-clock FIFO for the continuous monitoring system, buffering trace items between the monitor front-end and the consumer side (DMA/AXI-stream packer). It extends the basic counter-based FIFO with arbitrary (non-power-of-two) depth, a selectable first-word-fall-through or registered-read mode, programmable almost-full/almost-empty levels, synchronous flush, sticky overflow/underflow flags and a peak-occupancy register for software diagnostics.

## Interface
- DATA_WIDTH, 32, width of one entry
- DATA_DEPTH, 8, number of entries, any value >= 2
- SHOW_AHEAD, 1, 1 = first-word fall-through; 0 = registered read with rd_valid
- AF_LEVEL, DATA_DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
- CW (local), $clog2(DATA_DEPTH+1), count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  SHOW_AHEAD=0: rd_data updated this cycle; SHOW_AHEAD=1: equals !empty
- flush  in  1  synchronous discard of all contents
- clr_flags  in  1  clears overflow, underflow, peak
- full, empty, almost_full, almost_empty  out  1  status
- count  out  CW  current occupancy
- peak  out  CW  highest count since reset/clr_flags
- overflow, underflow  out  1  sticky error flags

## Operation
- wr_acc = wr_en & !full; rd_acc = rd_en & !empty (both from registered count, pre-edge values).
- Write with wr_acc stores at wr_ptr, wr_ptr advances; read with rd_acc advances rd_ptr.
- Pointers range 0..DATA_DEPTH-1, wrap to 0 after DATA_DEPTH-1 (explicit compare, not power-of-two overflow).
- count next = count + wr_acc - rd_acc; simultaneous accepted read+write leaves count unchanged.
- Full + rd_en + wr_en: read accepted, write rejected, overflow set, count -> DATA_DEPTH-1.
- Empty + rd_en + wr_en: write accepted, read rejected, underflow set, count -> 1.
- overflow sets on wr_en & full; underflow sets on rd_en & empty; both hold until clr_flags or reset.
- peak next = max(peak, count next); clr_flags loads peak with count next.
- flush: pointers and count to 0 next cycle; overrides wr_en/rd_en that cycle (no flag sets, no rd_valid); flags and peak unaffected unless clr_flags also asserted (peak then 0).
- clr_flags with a simultaneous error event: the event wins (flag ends set).
- Status combinational from count: full = (count==DATA_DEPTH), empty = (count==0), almost_full/almost_empty per parameters.
- Storage array is not reset.

## Timing
- Reset values: count 0, peak 0, pointers 0, empty 1, almost_empty 1, full 0, almost_full 0 (AF_LEVEL>0), overflow 0, underflow 0, rd_valid 0 (SHOW_AHEAD=0) / 0 (SHOW_AHEAD=1), rd_data 0 in SHOW_AHEAD=0.
- Write-to-visible latency: status and count update the edge after wr_acc; in SHOW_AHEAD=1, the entry appears on rd_data one cycle after its write into an empty FIFO.
- SHOW_AHEAD=1: rd_data = mem[rd_ptr] continuously; valid whenever !empty; don't-care when empty. Asserting rd_en consumes the displayed word at that edge.
- SHOW_AHEAD=0: on rd_acc, rd_data register loads mem[rd_ptr] at that edge; rd_valid is a 1-cycle pulse in the following cycle; rd_data holds between reads.
- Reset assertion mid-operation: all state clears immediately, independent of clk.

## Structure
- Sub-module trace_fifo_ram: simple dual-port array, one write port, asynchronous read port, no reset.
- Shared monitoring package: none required; CW computed locally.
- Top: pointer/count logic, flag/peak registers, SHOW_AHEAD generate branch for output register.

## Test plan
- DEPTH=8: write 0x10..0x17 -> full=1 after 8th edge, count=8, almost_full at count 6; 9th write -> overflow=1, count stays 8, 0x10 still head.
- Read 8 words from full -> data 0x10..0x17 in order, empty=1; extra rd_en -> underflow=1, count 0.
- DEPTH=5 (non-power-of-two): 3 writes, 3 reads, repeat 4 times -> pointers wrap, data order preserved, peak=3.
- Simultaneous rd_en+wr_en at count 4 -> count 4; at empty -> count 1, underflow=1; at full -> count 7, overflow=1.
- SHOW_AHEAD=0: write 0xA5, rd_en one cycle -> rd_valid pulse next cycle with rd_data=0xA5, data held afterward.
- count 5 + flush with wr_en -> count 0, empty=1, peak=5 retained; clr_flags -> overflow/underflow 0, peak 0; rst_n low mid-burst -> all outputs at reset values immediately.
